// File: rtl/alu_sequencer.sv
// Multi-cycle issue controller for a 32-bit combinational ALU: latches one
// operation per start/done handshake, holds the ALU inputs for a per-op settle time, then captures Z.
module alu_sequencer #(
  parameter int SIMPLE_CYCLES = 1,
  parameter int MUL_CYCLES    = 4,
  parameter int DIV_CYCLES    = 8
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [4:0]  op_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_zlow,
  input  logic [31:0] alu_zhigh,
  output logic [31:0] z_low,
  output logic [31:0] z_high,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [4:0] OP_MUL = 5'd10;
  localparam logic [4:0] OP_DIV = 5'd11;

  localparam int MAX_A      = (SIMPLE_CYCLES > MUL_CYCLES) ? SIMPLE_CYCLES : MUL_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > DIV_CYCLES) ? MAX_A : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, capture, reject;

  function automatic logic [CNT_W-1:0] settle_count(input logic [4:0] op);
    int lat;
    if (op == OP_MUL)      lat = MUL_CYCLES;
    else if (op == OP_DIV) lat = DIV_CYCLES;
    else                   lat = SIMPLE_CYCLES;
    return CNT_W'(lat - 1);
  endfunction

  assign reject = (op_in > OP_DIV) || ((op_in == OP_DIV) && (b_in == '0));

  // FINISH doubles as an accept state so back-to-back requests see no idle bubble.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE, FINISH: begin
        if (state_q == FINISH) state_d = IDLE;
        if (start) begin
          accept = 1'b1;
          if (reject) begin
            state_d = FINISH;
          end else begin
            state_d = EXEC;
            cnt_d   = settle_count(op_in);
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      z_low  <= '0;
      z_high <= '0;
      err    <= 1'b0;
    end else begin
      err <= accept && reject;
      if (accept) begin
        alu_a  <= a_in;
        alu_b  <= b_in;
        alu_op <= op_in;
      end
      if (capture) begin
        z_low  <= alu_zlow;
        z_high <= alu_zhigh;
      end
    end
  end

  assign busy = (state_q == EXEC);
  assign done = (state_q == FINISH);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU stands in for the real one,
// and a transaction-level model predicts latency, err and the captured Z pair.
module tb_alu_sequencer;

  localparam int SIMPLE_CYCLES = 1;
  localparam int MUL_CYCLES    = 4;
  localparam int DIV_CYCLES    = 8;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start;
  logic [4:0]  op_in;
  logic [31:0] a_in, b_in;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_zlow, alu_zhigh;
  logic [31:0] z_low, z_high;
  logic        busy, done, err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] zl_m = '0;
  logic [31:0] zh_m = '0;

  alu_sequencer #(
    .SIMPLE_CYCLES(SIMPLE_CYCLES),
    .MUL_CYCLES   (MUL_CYCLES),
    .DIV_CYCLES   (DIV_CYCLES)
  ) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .start    (start),
    .op_in    (op_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_zlow (alu_zlow),
    .alu_zhigh(alu_zhigh),
    .z_low    (z_low),
    .z_high   (z_high),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  // Stand-in combinational ALU; returns {high, low}.
  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (op)
      5'd0:  begin s = 33'(a) + 33'(b); return {31'b0, s}; end
      5'd1:  begin s = 33'(a) - 33'(b); return {31'b0, s}; end
      5'd2:  return {a ^ b, a & b};
      5'd3:  return {a ^ b, a | b};
      5'd4:  return {a & b, a ^ b};
      5'd5:  return {a, a << b[4:0]};
      5'd6:  return {b, a >> b[4:0]};
      5'd7:  return {~b, a[30:0], a[31]};
      5'd8:  return {b, ~a};
      5'd9:  return {a, 32'(-a)};
      5'd10: return 64'(a) * 64'(b);
      5'd11: return (b == 0) ? 64'd0 : {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  assign {alu_zhigh, alu_zlow} = alu_ref(alu_op, alu_a, alu_b);

  function automatic logic is_reject(input logic [4:0] op, input logic [31:0] b);
    return (op >= 5'd12) || (op == 5'd11 && b == 0);
  endfunction

  // Edges after the accept edge until done is visible.
  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] b);
    if (is_reject(op, b)) return 0;
    if (op == 5'd10) return MUL_CYCLES;
    if (op == 5'd11) return DIV_CYCLES;
    return SIMPLE_CYCLES;
  endfunction

  // Issues one request from a negedge and returns what was seen at the done cycle.
  task automatic do_txn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_seen, output logic err_seen,
                        output logic [31:0] zl, output logic [31:0] zh);
    for (int g = 0; g < 64 && busy; g++) @(negedge clock);
    start = 1'b1; op_in = op; a_in = a; b_in = b;
    @(posedge clock);
    #1;
    start = 1'b0; op_in = 5'($urandom); a_in = $urandom; b_in = $urandom;
    lat = -1; busy_seen = 1'b0; err_seen = 1'b0; zl = '0; zh = '0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (k == 0) busy_seen = busy;
      if (done) begin
        lat = k; err_seen = err; zl = z_low; zh = z_high;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0; start = 1'b0; op_in = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clock);
    n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, err}); else n_pass++;
    n_checks++; if ({z_high, z_low} !== 64'd0) $display("FAIL reset_z: got %h want 0", {z_high, z_low}); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_op} !== 69'd0) $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_op}); else n_pass++;
    clear_n = 1'b1;
    zl_m = '0; zh_m = '0;
    @(negedge clock);
  endtask

  task automatic test_add();
    int lat; logic bs, es; logic [31:0] zl, zh;
    do_txn(5'd0, 32'd5, 32'd7, lat, bs, es, zl, zh);
    n_checks++; if (lat !== SIMPLE_CYCLES) $display("FAIL add_latency: got %0d want %0d", lat, SIMPLE_CYCLES); else n_pass++;
    n_checks++; if (bs !== 1'b1) $display("FAIL add_busy: got %b want 1", bs); else n_pass++;
    n_checks++; if (zl !== 32'd12 || zh !== 32'd0) $display("FAIL add_z: got %0d/%0d want 12/0", zl, zh); else n_pass++;
    n_checks++; if (es !== 1'b0) $display("FAIL add_err: got %b want 0", es); else n_pass++;
    zl_m = 32'd12; zh_m = 32'd0;
  endtask

  task automatic test_mul();
    int lat; logic bs, es; logic [31:0] zl, zh;
    do_txn(5'd10, 32'h10000, 32'h10000, lat, bs, es, zl, zh);
    n_checks++; if (lat !== MUL_CYCLES) $display("FAIL mul_latency: got %0d want %0d", lat, MUL_CYCLES); else n_pass++;
    n_checks++; if (zh !== 32'd1 || zl !== 32'd0) $display("FAIL mul_z: got %h_%h want 00000001_00000000", zh, zl); else n_pass++;
    zl_m = 32'd0; zh_m = 32'd1;
  endtask

  task automatic test_div();
    int lat; logic bs, es; logic [31:0] zl, zh;
    do_txn(5'd11, 32'd100, 32'd7, lat, bs, es, zl, zh);
    n_checks++; if (lat !== DIV_CYCLES) $display("FAIL div_latency: got %0d want %0d", lat, DIV_CYCLES); else n_pass++;
    n_checks++; if (zl !== 32'd14 || zh !== 32'd2 || es !== 1'b0) $display("FAIL div_z: got q=%0d r=%0d err=%b want 14 2 0", zl, zh, es); else n_pass++;
    zl_m = 32'd14; zh_m = 32'd2;
    do_txn(5'd11, 32'd100, 32'd0, lat, bs, es, zl, zh);
    n_checks++; if (lat !== 0) $display("FAIL div0_latency: got %0d want 0", lat); else n_pass++;
    n_checks++; if (es !== 1'b1) $display("FAIL div0_err: got %b want 1", es); else n_pass++;
    n_checks++; if (zl !== 32'd14 || zh !== 32'd2) $display("FAIL div0_z_kept: got %0d/%0d want 14/2", zl, zh); else n_pass++;
    n_checks++; if (alu_b !== 32'd0 || alu_op !== 5'd11) $display("FAIL div0_alu_loaded: got b=%0d op=%0d want 0 11", alu_b, alu_op); else n_pass++;
    @(negedge clock);
    n_checks++; if (err !== 1'b0 || done !== 1'b0) $display("FAIL div0_err_clear: got err=%b done=%b want 0 0", err, done); else n_pass++;
  endtask

  task automatic test_illegal();
    int lat; logic bs, es; logic [31:0] zl, zh;
    do_txn(5'd20, 32'hdead_beef, 32'h1234_5678, lat, bs, es, zl, zh);
    n_checks++; if (lat !== 0 || es !== 1'b1) $display("FAIL illegal_done_err: got lat=%0d err=%b want 0 1", lat, es); else n_pass++;
    n_checks++; if (bs !== 1'b0) $display("FAIL illegal_busy: got %b want 0", bs); else n_pass++;
    n_checks++; if (zl !== zl_m || zh !== zh_m) $display("FAIL illegal_z_kept: got %h/%h want %h/%h", zl, zh, zl_m, zh_m); else n_pass++;
    n_checks++; if (alu_op !== 5'd20 || alu_a !== 32'hdead_beef) $display("FAIL illegal_alu_loaded: got op=%0d a=%h want 20 deadbeef", alu_op, alu_a); else n_pass++;
  endtask

  task automatic test_ignore_busy();
    int dn;
    logic [31:0] a, b, zl, zh;
    a = $urandom; b = $urandom; dn = 0; zl = '0; zh = '0;
    start = 1'b1; op_in = 5'd10; a_in = a; b_in = b;
    @(posedge clock);
    #1 start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) begin dn++; zl = z_low; zh = z_high; end
      if (i == 1) begin start = 1'b1; op_in = 5'd1; a_in = $urandom; b_in = $urandom; end
      if (i == 2) start = 1'b0;
    end
    {zh_m, zl_m} = alu_ref(5'd10, a, b);
    n_checks++; if (dn !== 1) $display("FAIL ignore_busy_done_count: got %0d want 1", dn); else n_pass++;
    n_checks++; if (alu_op !== 5'd10 || alu_a !== a) $display("FAIL ignore_busy_alu: got op=%0d a=%h want 10 %h", alu_op, alu_a, a); else n_pass++;
    n_checks++; if ({zh, zl} !== {zh_m, zl_m}) $display("FAIL ignore_busy_z: got %h want %h", {zh, zl}, {zh_m, zl_m}); else n_pass++;
  endtask

  task automatic test_random();
    int lat, el; logic bs, es, rej; logic [31:0] zl, zh, a, b; logic [4:0] op;
    for (int t = 0; t < 40; t++) begin
      op = 5'($urandom_range(0, 15));
      if (op >= 5'd12) op = 5'($urandom_range(12, 31));
      a = $urandom; b = $urandom;
      if (op == 5'd11 && $urandom_range(0, 3) == 0) b = '0;
      rej = is_reject(op, b);
      el  = exp_lat(op, b);
      if (!rej) {zh_m, zl_m} = alu_ref(op, a, b);
      do_txn(op, a, b, lat, bs, es, zl, zh);
      n_checks++; if (lat !== el) $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", t, op, lat, el); else n_pass++;
      n_checks++; if (es !== rej || bs !== !rej) $display("FAIL rand_err_busy[%0d] op=%0d: got err=%b busy=%b want %b %b", t, op, es, bs, rej, !rej); else n_pass++;
      n_checks++; if (zl !== zl_m || zh !== zh_m) $display("FAIL rand_z[%0d] op=%0d: got %h/%h want %h/%h", t, op, zh, zl, zh_m, zl_m); else n_pass++;
      n_checks++; if (alu_op !== op || alu_a !== a || alu_b !== b) $display("FAIL rand_alu_hold[%0d]: got %0d %h %h want %0d %h %h", t, alu_op, alu_a, alu_b, op, a, b); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] expq[$];
    logic [63:0] e;
    logic [31:0] a, b;
    logic [4:0]  cur;
    a = $urandom; b = $urandom; cur = 5'd0;
    start = 1'b1; op_in = cur; a_in = a; b_in = b;
    @(posedge clock);
    expq.push_back(alu_ref(cur, a, b));
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      n_checks++; if (done !== logic'(i % 2 == 1)) $display("FAIL b2b_done[%0d]: got %b want %b", i, done, i % 2 == 1); else n_pass++;
      if (done) begin
        e = expq.pop_front();
        {zh_m, zl_m} = e;
        n_checks++; if ({z_high, z_low} !== e) $display("FAIL b2b_z[%0d]: got %h want %h", i, {z_high, z_low}, e); else n_pass++;
        cur = (cur == 5'd0) ? 5'd1 : 5'd0;
        op_in = cur;
        expq.push_back(alu_ref(cur, a, b));
      end
    end
    start = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_exec();
    int dn;
    dn = 0;
    start = 1'b1; op_in = 5'd11; a_in = $urandom; b_in = 32'd3;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (busy !== 1'b1) $display("FAIL midreset_pre_busy: got %b want 1", busy); else n_pass++;
    clear_n = 1'b0;
    #1;
    n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL midreset_flags: got %b want 000", {busy, done, err}); else n_pass++;
    n_checks++; if ({z_high, z_low} !== 64'd0) $display("FAIL midreset_z: got %h want 0", {z_high, z_low}); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_op} !== 69'd0) $display("FAIL midreset_alu: got %h want 0", {alu_a, alu_b, alu_op}); else n_pass++;
    @(negedge clock);
    clear_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done) dn++;
    end
    n_checks++; if (dn !== 0) $display("FAIL midreset_no_done: got %0d want 0", dn); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_illegal();
    test_ignore_busy();
    test_random();
    test_back_to_back();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
